load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sequential load/store unit between the RV32I core's ALU/regfile and a word-wide data memory.
//  - Accepts one load/store per valid/ready handshake.
//  - Checks alignment; generates byte enables and replicated write data.
//  - Drives a req/gnt + rvalid memory port and returns sign/zero-extended load data.
//  - Asserts busy so the core stalls its PC until the response.
// PARAMETERS
//  ADDR_W       12   word-address width of mem_addr (4096 x 32-bit words)
//  TIMEOUT_CYC  255  cycles spent in REQ+WAIT before aborting with an error (1..255)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       synchronous, active-high
//  req_valid      in   1       core presents an access
//  req_ready      out  1       LSU can accept (high only in IDLE)
//  req_we         in   1       1 = store, 0 = load
//  req_funct3     in   3       RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr       in   32      byte address from ALU
//  req_wdata      in   32      rs2 value for stores
//  busy           out  1       state != IDLE; core holds PC/regfile write
//  rsp_valid      out  1       one-cycle pulse: access complete
//  rsp_rdata      out  32      extended load data (0 for stores or on error)
//  rsp_err        out  1       misaligned, illegal funct3, or timeout (valid with rsp_valid)
//  rsp_timeout    out  1       error cause was timeout (valid with rsp_valid)
//  mem_req        out  1       memory request, held until mem_gnt
//  mem_gnt        in   1       memory accepts request this cycle
//  mem_we         out  1       write strobe
//  mem_addr       out  ADDR_W  word address = addr[ADDR_W+1:2]
//  mem_be         out  4       byte enables
//  mem_wdata      out  32      lane-replicated store data
//  mem_rvalid     in   1       read data valid (earliest the cycle after gnt)
//  mem_rdata      in   32      read word
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, all other outputs 0, counter 0, latched request cleared.
//  - Reset mid-operation: abandons the access; mem_req low the cycle after the reset edge.
//  - Stray mem_rvalid is ignored in any state other than WAIT.
//  - Handshake: accept on req_valid & req_ready. addr/we/funct3/wdata are registered, so core inputs may change afterwards.
//  - FSM IDLE->REQ on accept when legal. IDLE->RESP on accept with error (no memory access).
//  - FSM REQ: mem_req=1; on mem_gnt -> WAIT (load) or RESP (store).
//  - FSM WAIT: on mem_rvalid capture rdata -> RESP.
//  - FSM RESP: rsp_valid=1 one cycle -> IDLE.
//  - Legality: loads 000/001/010/100/101; stores 000/001/010; others illegal.
//  - Legality: half needs addr[0]=0; word needs addr[1:0]=00; violation -> rsp_err=1.
//  - Byte enables: SB be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}.
//  - Byte enables: SH be=4'b0011<<{addr[1],1'b0}, wdata={2{wd[15:0]}}.
//  - Byte enables: SW be=4'hF. Loads drive be=4'hF.
//  - Load data: sh = rdata >> (8*addr[1:0]); LB sext sh[7:0], LBU zext, LH sext sh[15:0], LHU zext, LW rdata.
//  - Timeout: counter clears on accept, increments each cycle in REQ or WAIT.
//  - Timeout: reaching TIMEOUT_CYC -> RESP with rsp_err=rsp_timeout=1, mem_req dropped.
//  - Simultaneous mem_gnt and timeout: grant wins.
//  - Latency (accept at cycle 0): store with gnt at 1 -> rsp_valid at 2.
//  - Latency (accept at cycle 0): load with gnt at 1, rvalid at 2 -> rsp_valid at 3.
//  - Latency (accept at cycle 0): error -> rsp_valid at 1.
//  - Next accept: earliest the cycle after RESP; no back-to-back overlap.
// STRUCTURE
//  - Package lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU).
//  - Package lsu_pkg: typedef enum logic [1:0] lsu_state_t {IDLE,REQ,WAIT,RESP}.
//  - Package lsu_pkg: function be_gen(funct3, addr[1:0]).
//  - Sub-module lsu_load_align (combinational): rdata, addr[1:0], funct3 -> extended result.
//  - Top: FSM, request registers, timeout counter.
// TESTING
//  - LW addr 0x100, gnt at +1, rvalid at +2, rdata 0xDEADBEEF -> mem_addr 0x040, rsp_rdata 0xDEADBEEF at cycle 3.
//  - LB addr 0x103, rdata 0x80FF1234 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
//  - SB addr 0x21, wdata 0x000000AB -> mem_be 0010, mem_wdata 0xABABABAB, mem_we 1; rsp_valid 1 cycle after gnt.
//  - LW addr 0x102 -> no mem_req, rsp_valid next cycle, rsp_err 1, rsp_rdata 0.
//  - funct3 011 load -> no mem_req, rsp_valid next cycle, rsp_err 1.
//  - Load, gnt withheld 255 cycles -> rsp_err=rsp_timeout=1, mem_req low afterwards.
//  - Reset asserted in WAIT -> IDLE, req_ready 1; later stray mem_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and byte-enable helper for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'hF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the read word down to the addressed lane and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] sh;

  // Lane select then extension by access type; word accesses are aligned so sh == rdata.
  always_comb begin
    sh = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   result = {24'h0, sh[7:0]};
      F3_H:    result = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   result = {16'h0, sh[15:0]};
      F3_W:    result = sh;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: one access at a time over a req/gnt + rvalid memory port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYC);

  lsu_state_t        state_q, state_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d, tout_q, tout_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              accept, legal, f3_ok, aligned, timeout_hit;
  logic [31:0]       load_result;
  logic              in_req;

  assign accept      = req_valid && req_ready;
  assign timeout_hit = (cnt_q + 8'd1) == TimeoutLim;

  // Legality of the incoming request: encoding allowed for the direction, and natural alignment.
  always_comb begin
    if (req_we) begin
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    end else begin
      f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
              (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    end
    case (req_funct3[1:0])
      2'b01:   aligned = (req_addr[0] == 1'b0);
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    legal = f3_ok && aligned;
  end

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .result (load_result)
  );

  // State and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture so the core may change its inputs after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[ADDR_W+1:0];
      wdata_q <= req_wdata;
    end
  end

  // Next-state logic; grant/rvalid take priority over an expiring timeout.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tout_d  = tout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 8'h0;
          rdata_d = 32'h0;
          tout_d  = 1'b0;
          err_d   = !legal;
          state_d = legal ? REQ : RESP;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt) begin
          state_d = we_q ? RESP : WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          rdata_d = load_result;
          state_d = RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; memory-side signals are only driven while a request is outstanding.
  always_comb begin
    in_req      = (state_q == REQ);
    req_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    rsp_valid   = (state_q == RESP);
    rsp_rdata   = rsp_valid ? rdata_q : 32'h0;
    rsp_err     = rsp_valid && err_q;
    rsp_timeout = rsp_valid && tout_q;
    mem_req     = in_req;
    mem_we      = in_req && we_q;
    mem_addr    = in_req ? addr_q[ADDR_W+1:2] : '0;
    mem_be      = 4'h0;
    mem_wdata   = 32'h0;
    if (in_req) begin
      mem_be = we_q ? be_gen(f3_q, addr_q[1:0]) : 4'hF;
    end
    if (in_req && we_q) begin
      case (f3_q)
        F3_B:    mem_wdata = {4{wdata_q[7:0]}};
        F3_H:    mem_wdata = {2{wdata_q[15:0]}};
        default: mem_wdata = wdata_q;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(12), .TIMEOUT_CYC(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .busy        (busy),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; it is accepted on the following edge (cycle 0 ends).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    check_eq("ready_before_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    // Scramble core inputs: the unit must use its registered copy.
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp,
                          input logic [11:0] exp_addr);
    issue(1'b0, f3, addr, 32'h0);
    mem_gnt = 1'b1;                              // cycle 1
    @(negedge clk);
    check_eq({tag, "_req"}, {31'h0, mem_req}, 32'h1);
    check_eq({tag, "_addr"}, {20'h0, mem_addr}, {20'h0, exp_addr});
    check_eq({tag, "_be_we"}, {27'h0, mem_be, mem_we}, {27'h0, 4'hF, 1'b0});
    @(posedge clk); #1;                          // cycle 2
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    check_eq({tag, "_early_rsp"}, {30'h0, rsp_valid, mem_req}, 32'h0);
    @(posedge clk); #1;                          // cycle 3
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check_eq({tag, "_rsp"}, {29'h0, rsp_valid, rsp_err, rsp_timeout}, 32'h4);
    check_eq({tag, "_rdata"}, rsp_rdata, exp);
    @(posedge clk); #1;                          // cycle 4
    @(negedge clk);
    check_eq({tag, "_idle"}, {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gnt_dly, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [11:0] exp_addr);
    issue(1'b1, f3, addr, wd);
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      check_eq({tag, "_held"}, {30'h0, mem_req, rsp_valid}, 32'h2);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    check_eq({tag, "_req_we"}, {30'h0, mem_req, mem_we}, 32'h3);
    check_eq({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
    check_eq({tag, "_wdata"}, mem_wdata, exp_wd);
    check_eq({tag, "_addr"}, {20'h0, mem_addr}, {20'h0, exp_addr});
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rsp"}, {29'h0, rsp_valid, rsp_err, mem_req}, 32'h4);
    check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
  endtask

  task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
    issue(we, f3, addr, 32'hFFFF_FFFF);
    @(negedge clk);                              // cycle 1
    check_eq({tag, "_rsp"}, {28'h0, mem_req, rsp_valid, rsp_err, rsp_timeout}, 32'h6);
    check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_after"}, {29'h0, mem_req, rsp_valid, req_ready}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hit;
    logic        req_at_last;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset_ctrl", {26'h0, req_ready, busy, rsp_valid, rsp_err, rsp_timeout, mem_req},
             32'h20);
    check_eq("reset_mem", {15'h0, mem_we, mem_addr, mem_be}, 32'h0);
    check_eq("reset_wd_rd", mem_wdata | rsp_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_load("lw",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 12'h040);
    run_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80, 12'h040);
    run_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080, 12'h040);
    run_load("lhu", 3'b101, 32'h0000_0102, 32'h80FF_1234, 32'h0000_80FF, 12'h040);
    run_load("lh",  3'b001, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF, 12'h040);
    run_load("lb0", 3'b000, 32'h0000_4101, 32'h80FF_1234, 32'h0000_0012, 12'h040);

    run_store("sb", 3'b000, 32'h0000_0021, 32'h0000_00AB, 0, 4'b0010, 32'hABAB_ABAB, 12'h008);
    run_store("sh", 3'b001, 32'h0000_0022, 32'h1234_ABCD, 2, 4'b1100, 32'hABCD_ABCD, 12'h008);
    run_store("sw", 3'b010, 32'h0000_3FFC, 32'h0BAD_F00D, 1, 4'hF, 32'h0BAD_F00D, 12'hFFF);

    run_err("lw_mis",  1'b0, 3'b010, 32'h0000_0102);
    run_err("ld_f3",   1'b0, 3'b011, 32'h0000_0100);
    run_err("sh_mis",  1'b1, 3'b001, 32'h0000_0023);
    run_err("st_f3",   1'b1, 3'b100, 32'h0000_0100);

    // Timeout: grant withheld; cycles 1..255 in REQ, response in cycle 256.
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    hit = 0; req_at_last = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 255) req_at_last = mem_req;
      if (rsp_valid) begin
        hit = c;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("tout_cycle", hit, 256);
    check_eq("tout_req_255", {31'h0, req_at_last}, 32'h1);
    check_eq("tout_rsp", {29'h0, rsp_err, rsp_timeout, mem_req}, 32'h6);
    @(posedge clk); #1;
    mem_gnt = 1'b1;                              // late grant must be ignored
    @(negedge clk);
    check_eq("tout_after", {29'h0, mem_req, rsp_valid, req_ready}, 32'h1);
    @(posedge clk); #1;
    mem_gnt = 1'b0;

    // Reset while waiting for read data; a later stray rvalid must not produce a response.
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    mem_gnt = 1'b1;                              // cycle 1
    @(posedge clk); #1;                          // cycle 2: in WAIT
    mem_gnt = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_eq("wait_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;                          // cycle 3
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_idle", {29'h0, mem_req, req_ready, busy}, 32'h2);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    check_eq("stray_rv0", {30'h0, rsp_valid, busy}, 32'h0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("stray_rv1", {30'h0, rsp_valid, busy}, 32'h0);

    // Unit still works after the abandoned access.
    run_load("lw_post", 3'b010, 32'h0000_0004, 32'hCAFE_0001, 32'hCAFE_0001, 12'h001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
